armleocpu_axi_lite_router: RTL and testbench
============================================

# armleocpu_axi_lite_router

AXI4-Lite 1-to-N address router that sits directly upstream of `armleocpu_clint` and other memory-mapped peripherals. It accepts transactions from the CPU-side AXI4-Lite master and decodes each address against per-slave base/mask pairs. Matched transactions are forwarded to exactly one downstream slave port. Unmapped addresses are completed internally with DECERR. Write and read paths are independent, each with one outstanding transaction.

## Interface
Parameters:
- `SLAVE_COUNT`, 2: number of downstream ports; valid range 1..8.
- `ADDR_WIDTH`, 32: address width on all ports.
- `SLAVE_BASE`, {32'h8000_0000, 32'h0200_0000}: flattened `SLAVE_COUNT*ADDR_WIDTH`. Slice `i` is the base of slave `i`. Slave 0 is the CLINT.
- `SLAVE_MASK`, {32'h8000_0000, 32'hFFFF_0000}: flattened. Slave `i` hits when `(addr & mask_i) == base_i`.

Ports. Upstream ports are `S_*`; downstream ports are `M_*` and flattened per slave (slice `i` = slave `i`):
- `clk` in 1: clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `S_AXI_AWADDR` in ADDR_WIDTH, `S_AXI_AWVALID` in 1, `S_AXI_AWREADY` out 1: upstream write-address channel.
- `S_AXI_WDATA` in 32, `S_AXI_WSTRB` in 4, `S_AXI_WVALID` in 1, `S_AXI_WREADY` out 1: upstream write-data channel.
- `S_AXI_BRESP` out 2, `S_AXI_BVALID` out 1, `S_AXI_BREADY` in 1: upstream write-response channel.
- `S_AXI_ARADDR` in ADDR_WIDTH, `S_AXI_ARVALID` in 1, `S_AXI_ARREADY` out 1: upstream read-address channel.
- `S_AXI_RDATA` out 32, `S_AXI_RRESP` out 2, `S_AXI_RVALID` out 1, `S_AXI_RREADY` in 1: upstream read-data channel.
- `M_AXI_AWADDR` out N*ADDR_WIDTH, `M_AXI_AWVALID` out N, `M_AXI_AWREADY` in N: downstream write-address channels.
- `M_AXI_WDATA` out N*32, `M_AXI_WSTRB` out N*4, `M_AXI_WVALID` out N, `M_AXI_WREADY` in N: downstream write-data channels.
- `M_AXI_BRESP` in N*2, `M_AXI_BVALID` in N, `M_AXI_BREADY` out N: downstream write-response channels.
- `M_AXI_ARADDR` out N*ADDR_WIDTH, `M_AXI_ARVALID` out N, `M_AXI_ARREADY` in N: downstream read-address channels.
- `M_AXI_RDATA` in N*32, `M_AXI_RRESP` in N*2, `M_AXI_RVALID` in N, `M_AXI_RREADY` out N: downstream read-data channels.

## Operation
- Decode priority: the lowest-index hit wins. No hit means DECERR (2'b11).
- The router does not check alignment. The slave reports misalignment (CLINT returns SLVERR 2'b10).
- **Write FSM:**
  - `W_IDLE`: `S_AXI_AWREADY`=1. On AWVALID, register the address and the one-hot select.
    - On a hit, go to `W_ADDR`.
    - On a miss, go to `W_DROP`.
  - `W_ADDR`: drive the registered address on the selected `M_AXI_AWADDR` with `M_AXI_AWVALID` high until that slave's AWREADY, then go to `W_DATA`.
  - `W_DATA`: pass W through combinationally to the selected slave (VALID forward, READY back). On the W handshake, go to `W_RESP`.
  - `W_RESP`: pass B through combinationally. On BVALID&&BREADY, go to `W_IDLE`.
  - `W_DROP`: `S_AXI_WREADY`=1. On WVALID, go to `W_ERR`. Write data is discarded.
  - `W_ERR`: `S_AXI_BVALID`=1 with BRESP=2'b11 until BREADY, then go to `W_IDLE`.
- **Read FSM:**
  - `R_IDLE`: `S_AXI_ARREADY`=1. On ARVALID, register the address and select, then go to `R_ADDR` (hit) or `R_ERR` (miss).
  - `R_ADDR`: hold ARVALID to the selected slave until its ARREADY, then go to `R_DATA`.
  - `R_DATA`: pass R through combinationally. On RVALID&&RREADY, go to `R_IDLE`.
  - `R_ERR`: `S_AXI_RVALID`=1, RDATA=0, RRESP=2'b11 until RREADY, then go to `R_IDLE`.
- Non-selected slaves always see VALID=0 and READY=0. `M_*ADDR`, `WDATA` and `WSTRB` may be broadcast to all slaves.
- Write and read FSMs run concurrently. Simultaneous AW and AR in `*_IDLE` are both accepted in the same cycle. A downstream slave such as the CLINT, which serialises internally, back-pressures via its READY signals.
- W arriving before AW is held, because `S_AXI_WREADY`=0 outside `W_DATA`/`W_DROP`.

## Timing
- Reset, asserted asynchronously at any time:
  - both FSMs go to IDLE;
  - every VALID/READY output is 0 while reset is held, except that `S_AXI_AWREADY`/`S_AXI_ARREADY` rise to 1 in the first cycle after release;
  - BRESP/RRESP/RDATA outputs are 0;
  - an in-flight transaction is abandoned; no response is generated.
- Address latency: an upstream AW/AR handshake in cycle 0 gives the downstream VALID in cycle 1.
- Data/response paths add zero cycles. R/B/W VALID and READY are combinational pass-throughs in the data/response states.
- DECERR: the BVALID/RVALID error response appears one cycle after the W handshake (write) or after the AR handshake (read).
- Throughput: at most one transaction per FSM per 3 cycles (IDLE→ADDR→DATA/RESP minimum).

## Structure
- Shared package `armleocpu_axi_pkg` holds:
  - response constants `AXI_RESP_OKAY`=2'b00, `AXI_RESP_SLVERR`=2'b10, `AXI_RESP_DECERR`=2'b11;
  - the write and read FSM state localparams.
- Sub-module `armleocpu_axi_lite_decoder`: combinational address → one-hot select plus `hit`, parameterised identically. It is instantiated once for AW and once for AR.

## Test plan
- Write 32'h0000_0001, WSTRB=4'hF to 32'h0200_0000 → slave 0 AWADDR=32'h0200_0000 one cycle after AW; W forwarded; slave BRESP=00 returned; slave 1 VALIDs stay 0.
- Read 32'h8000_0010 with slave 1 returning RDATA=32'hDEAD_BEEF, RRESP=00, while RREADY is held low for 3 cycles → RVALID held, data stable, completion on handshake.
- Write to 32'h1000_0000 (unmapped) → AWREADY, WREADY taken, BRESP=2'b11; no downstream VALID ever asserted. Read to the same address → RDATA=0, RRESP=2'b11.
- AW to slave 0 and AR to slave 1 in the same cycle → both accepted in cycle 0; both downstream VALIDs in cycle 1; independent completion.
- Slave 0 holds AWREADY=0 for 5 cycles → `M_AXI_AWVALID[0]` stays 1 with a stable address; `S_AXI_WREADY` stays 0 throughout.
- `rst_n` asserted during `W_RESP` with BVALID pending → all outputs drop immediately; after release, `S_AXI_AWREADY`=1 and a new write completes normally.

Source files
------------

// File: rtl/armleocpu_axi_pkg.sv
// rtl/armleocpu_axi_pkg.sv - shared AXI4-Lite response codes and router FSM state types
//
// Purpose : constants and state encodings shared by the AXI4-Lite router and its decoder.
// Contents: AXI_RESP_* response codes, write FSM state type w_state_t, read FSM state type r_state_t.
package armleocpu_axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        W_IDLE = 3'd0,
        W_ADDR = 3'd1,
        W_DATA = 3'd2,
        W_RESP = 3'd3,
        W_DROP = 3'd4,
        W_ERR  = 3'd5
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2,
        R_ERR  = 2'd3
    } r_state_t;

endpackage

// File: rtl/armleocpu_axi_lite_router_if.sv
// rtl/armleocpu_axi_lite_router_if.sv - upstream and flattened downstream AXI4-Lite bundle of the router
//
// Purpose : groups the CPU-side S_AXI_* channels and the per-slave flattened M_AXI_* channels.
// Modports: slave  - the router's view (slave of the CPU bus, master of the downstream slaves)
//           master - the environment's view (CPU master plus downstream slave models)
interface armleocpu_axi_lite_router_if #(
    parameter int SLAVE_COUNT = 2,
    parameter int ADDR_WIDTH  = 32
);
    logic [ADDR_WIDTH-1:0]             S_AXI_AWADDR;
    logic                              S_AXI_AWVALID;
    logic                              S_AXI_AWREADY;
    logic [31:0]                       S_AXI_WDATA;
    logic [3:0]                        S_AXI_WSTRB;
    logic                              S_AXI_WVALID;
    logic                              S_AXI_WREADY;
    logic [1:0]                        S_AXI_BRESP;
    logic                              S_AXI_BVALID;
    logic                              S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]             S_AXI_ARADDR;
    logic                              S_AXI_ARVALID;
    logic                              S_AXI_ARREADY;
    logic [31:0]                       S_AXI_RDATA;
    logic [1:0]                        S_AXI_RRESP;
    logic                              S_AXI_RVALID;
    logic                              S_AXI_RREADY;

    logic [SLAVE_COUNT*ADDR_WIDTH-1:0] M_AXI_AWADDR;
    logic [SLAVE_COUNT-1:0]            M_AXI_AWVALID;
    logic [SLAVE_COUNT-1:0]            M_AXI_AWREADY;
    logic [SLAVE_COUNT*32-1:0]         M_AXI_WDATA;
    logic [SLAVE_COUNT*4-1:0]          M_AXI_WSTRB;
    logic [SLAVE_COUNT-1:0]            M_AXI_WVALID;
    logic [SLAVE_COUNT-1:0]            M_AXI_WREADY;
    logic [SLAVE_COUNT*2-1:0]          M_AXI_BRESP;
    logic [SLAVE_COUNT-1:0]            M_AXI_BVALID;
    logic [SLAVE_COUNT-1:0]            M_AXI_BREADY;
    logic [SLAVE_COUNT*ADDR_WIDTH-1:0] M_AXI_ARADDR;
    logic [SLAVE_COUNT-1:0]            M_AXI_ARVALID;
    logic [SLAVE_COUNT-1:0]            M_AXI_ARREADY;
    logic [SLAVE_COUNT*32-1:0]         M_AXI_RDATA;
    logic [SLAVE_COUNT*2-1:0]          M_AXI_RRESP;
    logic [SLAVE_COUNT-1:0]            M_AXI_RVALID;
    logic [SLAVE_COUNT-1:0]            M_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID, input S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARVALID, output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, input S_AXI_RREADY,
        output M_AXI_AWADDR, M_AXI_AWVALID, input M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARVALID, input M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, input S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, input S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID, output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARVALID, input S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, output S_AXI_RREADY,
        input  M_AXI_AWADDR, M_AXI_AWVALID, output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARVALID, output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
    );

endinterface

// File: rtl/armleocpu_axi_lite_decoder.sv
// rtl/armleocpu_axi_lite_decoder.sv - combinational address to one-hot slave select decoder
//
// Purpose : slave i hits when (i_addr & mask_i) == base_i; the lowest-index hit wins.
// Ports   : i_addr - address to decode
//           o_sel  - one-hot select, all zero on a miss
//           o_hit  - at least one slave matched
module armleocpu_axi_lite_decoder #(
    parameter int SLAVE_COUNT = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter logic [SLAVE_COUNT*ADDR_WIDTH-1:0] SLAVE_BASE = {32'h8000_0000, 32'h0200_0000},
    parameter logic [SLAVE_COUNT*ADDR_WIDTH-1:0] SLAVE_MASK = {32'h8000_0000, 32'hFFFF_0000}
) (
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    output logic [SLAVE_COUNT-1:0] o_sel,
    output logic                   o_hit
);

    always_comb begin
        logic w_found;
        w_found = 1'b0;
        o_sel   = '0;
        for (int i = 0; i < SLAVE_COUNT; i++) begin
            if (!w_found && ((i_addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])
                             == SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                o_sel[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
        o_hit = w_found;
    end

endmodule

// File: rtl/armleocpu_axi_lite_router.sv
// rtl/armleocpu_axi_lite_router.sv - AXI4-Lite 1-to-N address router with internal DECERR completion
//
// Purpose : routes each upstream transaction to exactly one downstream slave by base/mask decode;
//           unmapped addresses are completed here with DECERR. Independent write and read FSMs,
//           one outstanding transaction each.
// Ports   : clk   - clock
//           rst_n - asynchronous active-low reset
//           bus   - armleocpu_axi_lite_router_if.slave (S_AXI_* upstream, M_AXI_* flattened downstream)
module armleocpu_axi_lite_router
    import armleocpu_axi_pkg::*;
#(
    parameter int SLAVE_COUNT = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter logic [SLAVE_COUNT*ADDR_WIDTH-1:0] SLAVE_BASE = {32'h8000_0000, 32'h0200_0000},
    parameter logic [SLAVE_COUNT*ADDR_WIDTH-1:0] SLAVE_MASK = {32'h8000_0000, 32'hFFFF_0000}
) (
    input  logic clk,
    input  logic rst_n,
    armleocpu_axi_lite_router_if.slave bus
);

    w_state_t               r_wstate;
    logic [ADDR_WIDTH-1:0]  r_awaddr;
    logic [SLAVE_COUNT-1:0] r_wsel;
    logic                   r_s_awready;
    logic                   r_m_awvalid;
    logic                   r_drop_wready;
    logic                   r_err_bvalid;

    r_state_t               r_rstate;
    logic [ADDR_WIDTH-1:0]  r_araddr;
    logic [SLAVE_COUNT-1:0] r_rsel;
    logic                   r_s_arready;
    logic                   r_m_arvalid;
    logic                   r_err_rvalid;

    logic [SLAVE_COUNT-1:0] w_aw_sel;
    logic                   w_aw_hit;
    logic [SLAVE_COUNT-1:0] w_ar_sel;
    logic                   w_ar_hit;

    // Signals of the currently selected slave, muxed by the registered one-hot select
    logic                   w_sel_awready;
    logic                   w_sel_wready;
    logic                   w_sel_bvalid;
    logic [1:0]             w_sel_bresp;
    logic                   w_sel_arready;
    logic                   w_sel_rvalid;
    logic [1:0]             w_sel_rresp;
    logic [31:0]            w_sel_rdata;

    logic                   w_in_wdata;
    logic                   w_in_wresp;
    logic                   w_in_rdata;

    armleocpu_axi_lite_decoder #(
        .SLAVE_COUNT (SLAVE_COUNT),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .SLAVE_BASE  (SLAVE_BASE),
        .SLAVE_MASK  (SLAVE_MASK)
    ) u_aw_decoder (
        .i_addr (bus.S_AXI_AWADDR),
        .o_sel  (w_aw_sel),
        .o_hit  (w_aw_hit)
    );

    armleocpu_axi_lite_decoder #(
        .SLAVE_COUNT (SLAVE_COUNT),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .SLAVE_BASE  (SLAVE_BASE),
        .SLAVE_MASK  (SLAVE_MASK)
    ) u_ar_decoder (
        .i_addr (bus.S_AXI_ARADDR),
        .o_sel  (w_ar_sel),
        .o_hit  (w_ar_hit)
    );

    always_comb begin
        w_sel_awready = 1'b0;
        w_sel_wready  = 1'b0;
        w_sel_bvalid  = 1'b0;
        w_sel_bresp   = 2'b00;
        w_sel_arready = 1'b0;
        w_sel_rvalid  = 1'b0;
        w_sel_rresp   = 2'b00;
        w_sel_rdata   = 32'h0;
        for (int i = 0; i < SLAVE_COUNT; i++) begin
            if (r_wsel[i]) begin
                w_sel_awready = bus.M_AXI_AWREADY[i];
                w_sel_wready  = bus.M_AXI_WREADY[i];
                w_sel_bvalid  = bus.M_AXI_BVALID[i];
                w_sel_bresp   = bus.M_AXI_BRESP[i*2 +: 2];
            end
            if (r_rsel[i]) begin
                w_sel_arready = bus.M_AXI_ARREADY[i];
                w_sel_rvalid  = bus.M_AXI_RVALID[i];
                w_sel_rresp   = bus.M_AXI_RRESP[i*2 +: 2];
                w_sel_rdata   = bus.M_AXI_RDATA[i*32 +: 32];
            end
        end
    end

    // Write FSM. AWREADY is a register so it stays low while reset is held and
    // rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate      <= W_IDLE;
            r_awaddr      <= '0;
            r_wsel        <= '0;
            r_s_awready   <= 1'b0;
            r_m_awvalid   <= 1'b0;
            r_drop_wready <= 1'b0;
            r_err_bvalid  <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    r_s_awready <= 1'b1;
                    if (r_s_awready && bus.S_AXI_AWVALID) begin
                        r_awaddr    <= bus.S_AXI_AWADDR;
                        r_wsel      <= w_aw_sel;
                        r_s_awready <= 1'b0;
                        if (w_aw_hit) begin
                            r_wstate    <= W_ADDR;
                            r_m_awvalid <= 1'b1;
                        end else begin
                            r_wstate      <= W_DROP;
                            r_drop_wready <= 1'b1;
                        end
                    end
                end
                W_ADDR: begin
                    if (w_sel_awready) begin
                        r_m_awvalid <= 1'b0;
                        r_wstate    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (bus.S_AXI_WVALID && w_sel_wready) begin
                        r_wstate <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (w_sel_bvalid && bus.S_AXI_BREADY) begin
                        r_wstate    <= W_IDLE;
                        r_s_awready <= 1'b1;
                    end
                end
                W_DROP: begin
                    if (bus.S_AXI_WVALID) begin
                        r_drop_wready <= 1'b0;
                        r_err_bvalid  <= 1'b1;
                        r_wstate      <= W_ERR;
                    end
                end
                W_ERR: begin
                    if (bus.S_AXI_BREADY) begin
                        r_err_bvalid <= 1'b0;
                        r_wstate     <= W_IDLE;
                        r_s_awready  <= 1'b1;
                    end
                end
                default: begin
                    r_wstate      <= W_IDLE;
                    r_s_awready   <= 1'b0;
                    r_m_awvalid   <= 1'b0;
                    r_drop_wready <= 1'b0;
                    r_err_bvalid  <= 1'b0;
                end
            endcase
        end
    end

    // Read FSM, same shape as the write side without a separate data phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate     <= R_IDLE;
            r_araddr     <= '0;
            r_rsel       <= '0;
            r_s_arready  <= 1'b0;
            r_m_arvalid  <= 1'b0;
            r_err_rvalid <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_s_arready <= 1'b1;
                    if (r_s_arready && bus.S_AXI_ARVALID) begin
                        r_araddr    <= bus.S_AXI_ARADDR;
                        r_rsel      <= w_ar_sel;
                        r_s_arready <= 1'b0;
                        if (w_ar_hit) begin
                            r_rstate    <= R_ADDR;
                            r_m_arvalid <= 1'b1;
                        end else begin
                            r_rstate     <= R_ERR;
                            r_err_rvalid <= 1'b1;
                        end
                    end
                end
                R_ADDR: begin
                    if (w_sel_arready) begin
                        r_m_arvalid <= 1'b0;
                        r_rstate    <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (w_sel_rvalid && bus.S_AXI_RREADY) begin
                        r_rstate    <= R_IDLE;
                        r_s_arready <= 1'b1;
                    end
                end
                R_ERR: begin
                    if (bus.S_AXI_RREADY) begin
                        r_err_rvalid <= 1'b0;
                        r_rstate     <= R_IDLE;
                        r_s_arready  <= 1'b1;
                    end
                end
                default: begin
                    r_rstate     <= R_IDLE;
                    r_s_arready  <= 1'b0;
                    r_m_arvalid  <= 1'b0;
                    r_err_rvalid <= 1'b0;
                end
            endcase
        end
    end

    assign w_in_wdata = (r_wstate == W_DATA);
    assign w_in_wresp = (r_wstate == W_RESP);
    assign w_in_rdata = (r_rstate == R_DATA);

    // Address and write payload are broadcast; only VALID/READY are steered.
    assign bus.M_AXI_AWADDR  = {SLAVE_COUNT{r_awaddr}};
    assign bus.M_AXI_AWVALID = r_wsel & {SLAVE_COUNT{r_m_awvalid}};
    assign bus.M_AXI_WDATA   = {SLAVE_COUNT{bus.S_AXI_WDATA}};
    assign bus.M_AXI_WSTRB   = {SLAVE_COUNT{bus.S_AXI_WSTRB}};
    assign bus.M_AXI_WVALID  = r_wsel & {SLAVE_COUNT{w_in_wdata && bus.S_AXI_WVALID}};
    assign bus.M_AXI_BREADY  = r_wsel & {SLAVE_COUNT{w_in_wresp && bus.S_AXI_BREADY}};
    assign bus.M_AXI_ARADDR  = {SLAVE_COUNT{r_araddr}};
    assign bus.M_AXI_ARVALID = r_rsel & {SLAVE_COUNT{r_m_arvalid}};
    assign bus.M_AXI_RREADY  = r_rsel & {SLAVE_COUNT{w_in_rdata && bus.S_AXI_RREADY}};

    assign bus.S_AXI_AWREADY = r_s_awready;
    assign bus.S_AXI_WREADY  = (w_in_wdata && w_sel_wready) || r_drop_wready;
    assign bus.S_AXI_BVALID  = (w_in_wresp && w_sel_bvalid) || r_err_bvalid;
    assign bus.S_AXI_BRESP   = w_in_wresp   ? w_sel_bresp :
                               r_err_bvalid ? AXI_RESP_DECERR : AXI_RESP_OKAY;
    assign bus.S_AXI_ARREADY = r_s_arready;
    assign bus.S_AXI_RVALID  = (w_in_rdata && w_sel_rvalid) || r_err_rvalid;
    assign bus.S_AXI_RRESP   = w_in_rdata   ? w_sel_rresp :
                               r_err_rvalid ? AXI_RESP_DECERR : AXI_RESP_OKAY;
    assign bus.S_AXI_RDATA   = w_in_rdata ? w_sel_rdata : 32'h0;

endmodule

// File: tb/tb_armleocpu_axi_lite_router.sv
// tb/tb_armleocpu_axi_lite_router.sv - self-checking bench for the AXI4-Lite router
module tb_armleocpu_axi_lite_router;
    import armleocpu_axi_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    armleocpu_axi_lite_router_if #(.SLAVE_COUNT(2), .ADDR_WIDTH(32)) bus();

    armleocpu_axi_lite_router #(
        .SLAVE_COUNT (2),
        .ADDR_WIDTH  (32),
        .SLAVE_BASE  ({32'h8000_0000, 32'h0200_0000}),
        .SLAVE_MASK  ({32'h8000_0000, 32'hFFFF_0000})
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  exp_b[$];
    logic [33:0] exp_r[$];
    logic [1:0]  e_b;
    logic [33:0] e_r;

    logic [1:0] seen_valid = 2'b00;
    always @(posedge clk) seen_valid = seen_valid | bus.M_AXI_AWVALID | bus.M_AXI_WVALID | bus.M_AXI_ARVALID;

    task automatic idle_inputs();
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        bus.M_AXI_AWREADY = '0; bus.M_AXI_WREADY = '0;
        bus.M_AXI_BRESP = '0; bus.M_AXI_BVALID = '0;
        bus.M_AXI_ARREADY = '0;
        bus.M_AXI_RDATA = '0; bus.M_AXI_RRESP = '0; bus.M_AXI_RVALID = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        n_checks++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_ARREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 5'b0) begin
            n_fail++; $display("FAIL reset_upstream_flags: got %b expected 00000",
                {bus.S_AXI_AWREADY, bus.S_AXI_ARREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID});
        end
        n_checks++;
        if ({bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA} !== 36'h0) begin
            n_fail++; $display("FAIL reset_resp_data: got %h expected 0", {bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA});
        end
        n_checks++;
        if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID, bus.M_AXI_BREADY, bus.M_AXI_RREADY} !== 10'b0) begin
            n_fail++; $display("FAIL reset_downstream: got %b expected 0",
                {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID, bus.M_AXI_BREADY, bus.M_AXI_RREADY});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_ARREADY} !== 2'b11) begin
            n_fail++; $display("FAIL reset_release_ready: got %b expected 11", {bus.S_AXI_AWREADY, bus.S_AXI_ARREADY});
        end
    endtask

    task automatic test_write_slave0();
        seen_valid = 2'b00;
        bus.S_AXI_AWADDR = 32'h0200_0000; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h0000_0001; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        exp_b.push_back(AXI_RESP_OKAY);
        #1;
        n_checks++;
        if (bus.S_AXI_WREADY !== 1'b0) begin n_fail++; $display("FAIL wr0_early_w_held: got %b expected 0", bus.S_AXI_WREADY); end
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        n_checks++;
        if (bus.M_AXI_AWVALID !== 2'b01 || bus.M_AXI_AWADDR[31:0] !== 32'h0200_0000) begin
            n_fail++; $display("FAIL wr0_aw_fwd: got valid %b addr %h expected 01 02000000", bus.M_AXI_AWVALID, bus.M_AXI_AWADDR[31:0]);
        end
        bus.M_AXI_AWREADY = 2'b01;
        @(negedge clk);
        bus.M_AXI_AWREADY = 2'b00;
        n_checks++;
        if (bus.M_AXI_AWVALID !== 2'b00 || bus.M_AXI_WVALID !== 2'b01 || bus.M_AXI_WDATA[31:0] !== 32'h1 || bus.M_AXI_WSTRB[3:0] !== 4'hF) begin
            n_fail++; $display("FAIL wr0_w_fwd: got awv %b wv %b data %h strb %h expected 00 01 00000001 f",
                bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_WDATA[31:0], bus.M_AXI_WSTRB[3:0]);
        end
        bus.M_AXI_WREADY = 2'b01;
        #1;
        n_checks++;
        if (bus.S_AXI_WREADY !== 1'b1) begin n_fail++; $display("FAIL wr0_wready_pass: got %b expected 1", bus.S_AXI_WREADY); end
        @(negedge clk);
        bus.S_AXI_WVALID = 1'b0; bus.M_AXI_WREADY = 2'b00;
        bus.M_AXI_BVALID = 2'b01; bus.M_AXI_BRESP = 4'b0000; bus.S_AXI_BREADY = 1'b1;
        #1;
        n_checks++;
        if (bus.S_AXI_BVALID !== 1'b1 || bus.M_AXI_BREADY !== 2'b01) begin
            n_fail++; $display("FAIL wr0_b_pass: got bvalid %b bready %b expected 1 01", bus.S_AXI_BVALID, bus.M_AXI_BREADY);
        end
        n_checks++;
        if (exp_b.size() == 0) begin n_fail++; $display("FAIL wr0_bresp: got %b expected none queued", bus.S_AXI_BRESP); end
        else begin
            e_b = exp_b.pop_front();
            if (bus.S_AXI_BRESP !== e_b) begin n_fail++; $display("FAIL wr0_bresp: got %b expected %b", bus.S_AXI_BRESP, e_b); end
        end
        @(negedge clk);
        bus.M_AXI_BVALID = 2'b00; bus.S_AXI_BREADY = 1'b0;
        n_checks++;
        if (seen_valid[1] !== 1'b0 || bus.S_AXI_AWREADY !== 1'b1) begin
            n_fail++; $display("FAIL wr0_slave1_quiet: got seen %b awready %b expected 0 1", seen_valid[1], bus.S_AXI_AWREADY);
        end
    endtask

    task automatic test_read_stall();
        bus.S_AXI_ARADDR = 32'h8000_0010; bus.S_AXI_ARVALID = 1'b1;
        exp_r.push_back({AXI_RESP_OKAY, 32'hDEAD_BEEF});
        @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0;
        n_checks++;
        if (bus.M_AXI_ARVALID !== 2'b10 || bus.M_AXI_ARADDR[63:32] !== 32'h8000_0010) begin
            n_fail++; $display("FAIL rd1_ar_fwd: got %b %h expected 10 80000010", bus.M_AXI_ARVALID, bus.M_AXI_ARADDR[63:32]);
        end
        bus.M_AXI_ARREADY = 2'b10;
        @(negedge clk);
        bus.M_AXI_ARREADY = 2'b00;
        bus.M_AXI_RVALID = 2'b10; bus.M_AXI_RDATA[63:32] = 32'hDEAD_BEEF; bus.M_AXI_RRESP = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA !== 32'hDEAD_BEEF || bus.M_AXI_RREADY !== 2'b00) begin
                n_fail++; $display("FAIL rd1_stall_hold: cycle %0d got rv %b data %h rr %b expected 1 deadbeef 00",
                    c, bus.S_AXI_RVALID, bus.S_AXI_RDATA, bus.M_AXI_RREADY);
            end
            @(negedge clk);
        end
        bus.S_AXI_RREADY = 1'b1;
        #1;
        n_checks++;
        if (exp_r.size() == 0) begin n_fail++; $display("FAIL rd1_rdata: got %h expected none queued", bus.S_AXI_RDATA); end
        else begin
            e_r = exp_r.pop_front();
            if ({bus.S_AXI_RRESP, bus.S_AXI_RDATA} !== e_r || bus.M_AXI_RREADY !== 2'b10) begin
                n_fail++; $display("FAIL rd1_rdata: got %h rready %b expected %h 10", {bus.S_AXI_RRESP, bus.S_AXI_RDATA}, bus.M_AXI_RREADY, e_r);
            end
        end
        @(negedge clk);
        bus.S_AXI_RREADY = 1'b0; bus.M_AXI_RVALID = 2'b00; bus.M_AXI_RDATA = '0;
        n_checks++;
        if (bus.S_AXI_RVALID !== 1'b0 || bus.S_AXI_ARREADY !== 1'b1) begin
            n_fail++; $display("FAIL rd1_complete: got rv %b arready %b expected 0 1", bus.S_AXI_RVALID, bus.S_AXI_ARREADY);
        end
    endtask

    task automatic test_decerr();
        seen_valid = 2'b00;
        bus.S_AXI_AWADDR = 32'h1000_0000; bus.S_AXI_AWVALID = 1'b1;
        exp_b.push_back(AXI_RESP_DECERR);
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = 32'hCAFE_0000; bus.S_AXI_WVALID = 1'b1;
        #1;
        n_checks++;
        if (bus.S_AXI_WREADY !== 1'b1) begin n_fail++; $display("FAIL dec_wready: got %b expected 1", bus.S_AXI_WREADY); end
        @(negedge clk);
        bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b1;
        #1;
        n_checks++;
        if (exp_b.size() == 0) begin n_fail++; $display("FAIL dec_bresp: got %b expected none queued", bus.S_AXI_BRESP); end
        else begin
            e_b = exp_b.pop_front();
            if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== e_b) begin
                n_fail++; $display("FAIL dec_bresp: got bv %b resp %b expected 1 %b", bus.S_AXI_BVALID, bus.S_AXI_BRESP, e_b);
            end
        end
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = 32'h1000_0000; bus.S_AXI_ARVALID = 1'b1;
        exp_r.push_back({AXI_RESP_DECERR, 32'h0});
        @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b1;
        #1;
        n_checks++;
        if (exp_r.size() == 0) begin n_fail++; $display("FAIL dec_rresp: got %h expected none queued", bus.S_AXI_RDATA); end
        else begin
            e_r = exp_r.pop_front();
            if (bus.S_AXI_RVALID !== 1'b1 || {bus.S_AXI_RRESP, bus.S_AXI_RDATA} !== e_r) begin
                n_fail++; $display("FAIL dec_rresp: got rv %b %h expected 1 %h", bus.S_AXI_RVALID, {bus.S_AXI_RRESP, bus.S_AXI_RDATA}, e_r);
            end
        end
        @(negedge clk);
        bus.S_AXI_RREADY = 1'b0;
        n_checks++;
        if (seen_valid !== 2'b00 || bus.S_AXI_RVALID !== 1'b0 || bus.S_AXI_BVALID !== 1'b0) begin
            n_fail++; $display("FAIL dec_no_downstream: got seen %b rv %b bv %b expected 00 0 0", seen_valid, bus.S_AXI_RVALID, bus.S_AXI_BVALID);
        end
    endtask

    task automatic test_concurrent();
        bus.S_AXI_AWADDR = 32'h0200_0004; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_ARADDR = 32'h8000_0020; bus.S_AXI_ARVALID = 1'b1;
        #1;
        n_checks++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_ARREADY} !== 2'b11) begin
            n_fail++; $display("FAIL cc_accept: got %b expected 11", {bus.S_AXI_AWREADY, bus.S_AXI_ARREADY});
        end
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        n_checks++;
        if (bus.M_AXI_AWVALID !== 2'b01 || bus.M_AXI_ARVALID !== 2'b10) begin
            n_fail++; $display("FAIL cc_fwd: got aw %b ar %b expected 01 10", bus.M_AXI_AWVALID, bus.M_AXI_ARVALID);
        end
        bus.M_AXI_AWREADY = 2'b01; bus.M_AXI_ARREADY = 2'b10;
        @(negedge clk);
        bus.M_AXI_AWREADY = 2'b00; bus.M_AXI_ARREADY = 2'b00;
        bus.S_AXI_WDATA = 32'h5555_AAAA; bus.S_AXI_WSTRB = 4'h3; bus.S_AXI_WVALID = 1'b1; bus.M_AXI_WREADY = 2'b01;
        bus.M_AXI_RVALID = 2'b10; bus.M_AXI_RDATA[63:32] = 32'h1234_5678; bus.M_AXI_RRESP = 4'b0000; bus.S_AXI_RREADY = 1'b1;
        exp_r.push_back({AXI_RESP_OKAY, 32'h1234_5678});
        #1;
        n_checks++;
        if (exp_r.size() == 0) begin n_fail++; $display("FAIL cc_rdata: got %h expected none queued", bus.S_AXI_RDATA); end
        else begin
            e_r = exp_r.pop_front();
            if (bus.S_AXI_RVALID !== 1'b1 || {bus.S_AXI_RRESP, bus.S_AXI_RDATA} !== e_r) begin
                n_fail++; $display("FAIL cc_rdata: got rv %b %h expected 1 %h", bus.S_AXI_RVALID, {bus.S_AXI_RRESP, bus.S_AXI_RDATA}, e_r);
            end
        end
        @(negedge clk);
        bus.S_AXI_WVALID = 1'b0; bus.M_AXI_WREADY = 2'b00;
        bus.M_AXI_RVALID = 2'b00; bus.S_AXI_RREADY = 1'b0;
        bus.M_AXI_BVALID = 2'b01; bus.M_AXI_BRESP = 4'b0010; bus.S_AXI_BREADY = 1'b1;
        exp_b.push_back(AXI_RESP_SLVERR);
        #1;
        n_checks++;
        if (exp_b.size() == 0) begin n_fail++; $display("FAIL cc_bresp: got %b expected none queued", bus.S_AXI_BRESP); end
        else begin
            e_b = exp_b.pop_front();
            if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== e_b) begin
                n_fail++; $display("FAIL cc_bresp: got bv %b resp %b expected 1 %b", bus.S_AXI_BVALID, bus.S_AXI_BRESP, e_b);
            end
        end
        @(negedge clk);
        bus.M_AXI_BVALID = 2'b00; bus.M_AXI_BRESP = '0; bus.S_AXI_BREADY = 1'b0;
    endtask

    task automatic test_aw_backpressure();
        bus.S_AXI_AWADDR = 32'h0200_0008; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h0BAD_F00D; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        bus.M_AXI_WREADY = 2'b01;
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (bus.M_AXI_AWVALID[0] !== 1'b1 || bus.M_AXI_AWADDR[31:0] !== 32'h0200_0008 || bus.S_AXI_WREADY !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold: cycle %0d got awv %b addr %h wready %b expected 1 02000008 0",
                    c, bus.M_AXI_AWVALID[0], bus.M_AXI_AWADDR[31:0], bus.S_AXI_WREADY);
            end
            @(negedge clk);
        end
        bus.M_AXI_AWREADY = 2'b01;
        @(negedge clk);
        bus.M_AXI_AWREADY = 2'b00;
        n_checks++;
        if (bus.S_AXI_WREADY !== 1'b1) begin n_fail++; $display("FAIL bp_wready_after: got %b expected 1", bus.S_AXI_WREADY); end
        @(negedge clk);
        bus.S_AXI_WVALID = 1'b0; bus.M_AXI_WREADY = 2'b00;
        bus.M_AXI_BVALID = 2'b01; bus.M_AXI_BRESP = 4'b0000; bus.S_AXI_BREADY = 1'b1;
        exp_b.push_back(AXI_RESP_OKAY);
        #1;
        n_checks++;
        if (exp_b.size() == 0) begin n_fail++; $display("FAIL bp_bresp: got %b expected none queued", bus.S_AXI_BRESP); end
        else begin
            e_b = exp_b.pop_front();
            if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== e_b) begin
                n_fail++; $display("FAIL bp_bresp: got bv %b resp %b expected 1 %b", bus.S_AXI_BVALID, bus.S_AXI_BRESP, e_b);
            end
        end
        @(negedge clk);
        bus.M_AXI_BVALID = 2'b00; bus.S_AXI_BREADY = 1'b0;
    endtask

    task automatic test_reset_in_resp();
        int k;
        bus.S_AXI_AWADDR = 32'h0200_000C; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h7777_7777; bus.S_AXI_WVALID = 1'b1;
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0; bus.M_AXI_AWREADY = 2'b01;
        @(negedge clk);
        bus.M_AXI_AWREADY = 2'b00; bus.M_AXI_WREADY = 2'b01;
        @(negedge clk);
        bus.S_AXI_WVALID = 1'b0; bus.M_AXI_WREADY = 2'b00;
        bus.M_AXI_BVALID = 2'b01; bus.M_AXI_BRESP = 4'b0000;
        #1;
        n_checks++;
        if (bus.S_AXI_BVALID !== 1'b1) begin n_fail++; $display("FAIL rr_pending: got %b expected 1", bus.S_AXI_BVALID); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_ARREADY, bus.M_AXI_BREADY, bus.M_AXI_AWVALID} !== 7'b0) begin
            n_fail++; $display("FAIL rr_async_drop: got %b expected 0",
                {bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_ARREADY, bus.M_AXI_BREADY, bus.M_AXI_AWVALID});
        end
        @(negedge clk);
        rst_n = 1'b1; bus.M_AXI_BVALID = 2'b00;
        @(negedge clk);
        n_checks++;
        if (bus.S_AXI_AWREADY !== 1'b1 || bus.S_AXI_BVALID !== 1'b0) begin
            n_fail++; $display("FAIL rr_release: got awready %b bvalid %b expected 1 0", bus.S_AXI_AWREADY, bus.S_AXI_BVALID);
        end
        bus.S_AXI_AWADDR = 32'h0200_0010; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h0000_00AA; bus.S_AXI_WVALID = 1'b1;
        exp_b.push_back(AXI_RESP_OKAY);
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        k = 0;
        while (bus.M_AXI_AWVALID[0] !== 1'b1 && k < 8) begin @(negedge clk); k++; end
        n_checks++;
        if (bus.M_AXI_AWVALID[0] !== 1'b1 || bus.M_AXI_AWADDR[31:0] !== 32'h0200_0010) begin
            n_fail++; $display("FAIL rr_new_aw: got %b %h expected 1 02000010", bus.M_AXI_AWVALID[0], bus.M_AXI_AWADDR[31:0]);
        end
        bus.M_AXI_AWREADY = 2'b01;
        @(negedge clk);
        bus.M_AXI_AWREADY = 2'b00; bus.M_AXI_WREADY = 2'b01;
        @(negedge clk);
        bus.S_AXI_WVALID = 1'b0; bus.M_AXI_WREADY = 2'b00;
        bus.M_AXI_BVALID = 2'b01; bus.S_AXI_BREADY = 1'b1;
        #1;
        n_checks++;
        if (exp_b.size() == 0) begin n_fail++; $display("FAIL rr_new_bresp: got %b expected none queued", bus.S_AXI_BRESP); end
        else begin
            e_b = exp_b.pop_front();
            if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== e_b) begin
                n_fail++; $display("FAIL rr_new_bresp: got bv %b resp %b expected 1 %b", bus.S_AXI_BVALID, bus.S_AXI_BRESP, e_b);
            end
        end
        @(negedge clk);
        bus.M_AXI_BVALID = 2'b00; bus.S_AXI_BREADY = 1'b0;
        n_checks++;
        if (exp_b.size() != 0 || exp_r.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d/%0d left expected 0/0", exp_b.size(), exp_r.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_slave0();
        test_read_stall();
        test_decerr();
        test_concurrent();
        test_aw_backpressure();
        test_reset_in_resp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
